intr_trap_ctrl: RTL and testbench
=================================

Name: intr_trap_ctrl

Overview:
- Interrupt/trap sequencer for the single-cycle-issue RISC-V core.
- Synchronizes the external interrupt line and latches a pending request.
- At an instruction boundary, when the CSR interrupt enable is set, it takes the interrupt: pulses the CSR INT_TAKEN strobe, redirects the PC to the trap vector, and masks further interrupts.
- On MRET it redirects the PC to the saved return address and re-enables interrupts.

Parameters:
SYNC_STAGES, 2, flops in the INTR synchronizer chain (minimum 2).
CNT_W, 16, width of the saturating taken-interrupt counter.

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
INTR  in  1  external interrupt request, asynchronous level, rising edge = request
BOUNDARY  in  1  one-cycle pulse: current instruction retires this cycle, next fetch not yet issued
MRET  in  1  one-cycle pulse: MRET retiring this cycle (only meaningful with BOUNDARY)
CSR_MIE  in  1  interrupt enable from CSR file
CSR_MTVEC  in  32  trap handler address from CSR file
CSR_MEPC  in  32  return address from CSR file
INT_TAKEN  out  1  one-cycle strobe to CSR file (captures PC into MEPC)
MIE_CLR  out  1  one-cycle strobe: CSR file clears MIE
MIE_SET  out  1  one-cycle strobe: CSR file sets MIE
REDIRECT  out  1  one-cycle: fetch must use REDIRECT_ADDR next
REDIRECT_ADDR  out  32  redirect target
PENDING  out  1  latched, not-yet-taken request
IN_ISR  out  1  handler active
INT_COUNT  out  CNT_W  taken interrupts, saturating at all-ones

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - RST is synchronous and active-high, and wins over all other events in the same cycle.
- Reset values: all outputs 0; state IDLE; synchronizer flops 0; edge-detect history 0.
- Synchronizer and edge detect:
  - INTR passes through SYNC_STAGES flops.
  - A rising edge of the synchronized signal sets the pending flop.
  - Latency from INTR rising to PENDING=1 is SYNC_STAGES+1 clocks.
- Pending flop:
  - Set by an edge; cleared in the TAKE cycle.
  - If a set and a clear land in the same cycle, set wins.
  - Multiple edges before a take coalesce into one request.
- FSM states: IDLE, TAKE, ISR, RET. The state encoding lives in the package.
- IDLE:
  - BOUNDARY & PENDING & CSR_MIE goes to TAKE.
  - BOUNDARY & MRET (spurious) stays in IDLE. It outputs REDIRECT=1 with REDIRECT_ADDR=CSR_MEPC for one cycle and does not assert MIE_SET.
  - Interrupt priority is above MRET when both qualify.
- TAKE (exactly one cycle):
  - INT_TAKEN=1, MIE_CLR=1, REDIRECT=1, REDIRECT_ADDR=CSR_MTVEC.
  - Pending cleared; INT_COUNT+1 unless saturated.
  - Next state ISR.
- ISR:
  - IN_ISR=1.
  - New edges re-set PENDING, but no nesting occurs.
  - BOUNDARY & MRET goes to RET.
- RET (exactly one cycle):
  - REDIRECT=1, REDIRECT_ADDR=CSR_MEPC, MIE_SET=1; IN_ISR stays 1 during this cycle.
  - Next state IDLE.
  - A still-pending request may be taken from IDLE at the next BOUNDARY with CSR_MIE=1. This gives at least one instruction of forward progress, because CSR_MIE updates one clock after MIE_SET.
- Output timing:
  - All strobes are registered outputs of the state, asserted in the clock after the qualifying BOUNDARY.
  - REDIRECT_ADDR is combinational from the CSR inputs while REDIRECT=1, and 0 otherwise.
- Pulse-width rules:
  - BOUNDARY and MRET are sampled only in IDLE and ISR.
  - Pulses arriving during TAKE or RET are ignored; the core guarantees they do not occur, and assertions flag them.
- CSR_MIE deasserted while pending: the request stays pending indefinitely until MIE=1 at a boundary.
- RST mid-ISR: returns to IDLE, clears PENDING and INT_COUNT, and emits no redirect.

Decomposition:
- Package intr_pkg:
  - typedef enum intr_state_t {IDLE, TAKE, ISR, RET};
  - localparam CNT_W default;
  - CSR address constants (MIE 12'h304, MTVEC 12'h305, MEPC 12'h341), shared with the CSR file.
- Sub-module intr_sync:
  - Parameterized SYNC_STAGES flop chain plus rising-edge detector.
  - Outputs a one-cycle edge pulse.
  - Synchronous active-high RST on CLK.

Test Plan:
1. RST, then CSR_MIE=1, CSR_MTVEC=0x100, INTR rises at cycle 10, BOUNDARY at cycle 20 -> PENDING=1 at cycle 13; at cycle 21 INT_TAKEN=MIE_CLR=REDIRECT=1 with REDIRECT_ADDR=0x100; INT_COUNT=1; IN_ISR=1 from cycle 22.
2. In ISR with CSR_MEPC=0x44, BOUNDARY+MRET -> next cycle REDIRECT=1, REDIRECT_ADDR=0x44, MIE_SET=1; following cycle state IDLE, IN_ISR=0.
3. CSR_MIE=0, INTR pulses 3 times, 5 BOUNDARY pulses -> no INT_TAKEN, PENDING stays 1; raise CSR_MIE and pulse BOUNDARY -> exactly one take; INT_COUNT +1.
4. INTR edge during ISR, then MRET, CSR_MIE goes 1 one cycle after MIE_SET, next BOUNDARY -> second take to MTVEC; INT_COUNT=2.
5. RST asserted in the cycle after TAKE (state ISR, PENDING re-set) -> next cycle all outputs 0, state IDLE; a later BOUNDARY produces no redirect.
6. Force INT_COUNT to 0xFFFF via CNT_W=16, then take one more interrupt -> count remains 0xFFFF; spurious MRET in IDLE -> REDIRECT to CSR_MEPC, MIE_SET=0.

Source files
------------

// File: rtl/intr_trap_ctrl_pkg.sv
// Shared types and constants for the interrupt/trap sequencer and the CSR file.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    ISR  = 2'd2,
    RET  = 2'd3
  } intr_state_t;

  // Default width of the saturating taken-interrupt counter.
  localparam int unsigned INTR_CNT_W = 16;

  // CSR addresses, shared with the CSR file decoder.
  localparam logic [11:0] CSR_ADDR_MIE   = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_ADDR_MEPC  = 12'h341;

endpackage

// File: rtl/intr_trap_ctrl_sync.sv
// INTR synchronizer chain plus rising-edge detector producing a one-cycle pulse.
module intr_sync
  import intr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic INTR,
  output logic EDGE_PULSE
);

  // Fewer than two flops is not a safe synchronizer; clamp rather than build one.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] chain_q;
  logic              hist_q;

  // Shift the raw level through the chain and remember the last synchronized value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      chain_q <= '0;
      hist_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], INTR};
      hist_q  <= chain_q[STAGES-1];
    end
  end

  // Rising edge of the synchronized level.
  always_comb begin
    EDGE_PULSE = chain_q[STAGES-1] & ~hist_q;
  end

endmodule

// File: rtl/intr_trap_ctrl.sv
// Interrupt/trap sequencer: latches requests, takes them at instruction
// boundaries, and sequences the MRET return.
module intr_trap_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = INTR_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INTR,
  input  logic             BOUNDARY,
  input  logic             MRET,
  input  logic             CSR_MIE,
  input  logic [31:0]      CSR_MTVEC,
  input  logic [31:0]      CSR_MEPC,
  output logic             INT_TAKEN,
  output logic             MIE_CLR,
  output logic             MIE_SET,
  output logic             REDIRECT,
  output logic [31:0]      REDIRECT_ADDR,
  output logic             PENDING,
  output logic             IN_ISR,
  output logic [CNT_W-1:0] INT_COUNT
);

  intr_state_t      state_q, state_d;
  logic             spur_q, spur_d;
  logic             pending_q;
  logic             edge_p;
  logic [CNT_W-1:0] count_q;

  intr_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .INTR      (INTR),
    .EDGE_PULSE(edge_p)
  );

  // Next-state decode; a spurious MRET in IDLE only raises a one-cycle redirect flag.
  always_comb begin
    state_d = state_q;
    spur_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (BOUNDARY && pending_q && CSR_MIE) begin
          state_d = TAKE;
        end else if (BOUNDARY && MRET) begin
          spur_d = 1'b1;
        end
      end
      TAKE:    state_d = ISR;
      ISR:     if (BOUNDARY && MRET) state_d = RET;
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and spurious-redirect registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spur_q  <= spur_d;
    end
  end

  // Pending request: a new edge wins over the clear issued by TAKE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q <= 1'b0;
    end else if (edge_p) begin
      pending_q <= 1'b1;
    end else if (state_q == TAKE) begin
      pending_q <= 1'b0;
    end
  end

  // Saturating count of taken interrupts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if ((state_q == TAKE) && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Strobes decode from registered state; the redirect target follows the CSR inputs live.
  always_comb begin
    INT_TAKEN     = (state_q == TAKE);
    MIE_CLR       = (state_q == TAKE);
    MIE_SET       = (state_q == RET);
    REDIRECT      = (state_q == TAKE) || (state_q == RET) || spur_q;
    IN_ISR        = (state_q == ISR) || (state_q == RET);
    PENDING       = pending_q;
    INT_COUNT     = count_q;
    REDIRECT_ADDR = '0;
    if (state_q == TAKE) begin
      REDIRECT_ADDR = CSR_MTVEC;
    end else if ((state_q == RET) || spur_q) begin
      REDIRECT_ADDR = CSR_MEPC;
    end
  end

  // The core never retires an instruction during the one-cycle TAKE/RET states.
  a_no_pulse_in_oneshot: assert property (
    @(posedge CLK) disable iff (RST)
      ((state_q == TAKE) || (state_q == RET)) |-> !(BOUNDARY || MRET)
  );

endmodule

// File: tb/tb_intr_trap_ctrl.sv
// Bench for intr_trap_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_intr_trap_ctrl;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, intr_i = 1'b0, bnd_i = 1'b0, mret_i = 1'b0, mie_i = 1'b0;
  logic [31:0] mtvec_i = '0, mepc_i = '0;

  logic        taken, clr, set, redir, pend, isr;
  logic [31:0] addr;
  logic [15:0] cnt;

  logic        s_taken, s_clr, s_set, s_redir, s_pend, s_isr;
  logic [31:0] s_addr;
  logic [2:0]  s_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  intr_trap_ctrl #(.SYNC_STAGES(S), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst_i), .INTR(intr_i), .BOUNDARY(bnd_i), .MRET(mret_i),
    .CSR_MIE(mie_i), .CSR_MTVEC(mtvec_i), .CSR_MEPC(mepc_i),
    .INT_TAKEN(taken), .MIE_CLR(clr), .MIE_SET(set), .REDIRECT(redir),
    .REDIRECT_ADDR(addr), .PENDING(pend), .IN_ISR(isr), .INT_COUNT(cnt)
  );

  intr_trap_ctrl #(.SYNC_STAGES(S), .CNT_W(3)) dut_sat (
    .CLK(clk), .RST(rst_i), .INTR(intr_i), .BOUNDARY(bnd_i), .MRET(mret_i),
    .CSR_MIE(mie_i), .CSR_MTVEC(mtvec_i), .CSR_MEPC(mepc_i),
    .INT_TAKEN(s_taken), .MIE_CLR(s_clr), .MIE_SET(s_set), .REDIRECT(s_redir),
    .REDIRECT_ADDR(s_addr), .PENDING(s_pend), .IN_ISR(s_isr), .INT_COUNT(s_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: what happens in the cycle after each clock edge.
  bit          m_pend, m_inh, m_take, m_ret, m_spur;
  int unsigned m_takes;
  bit          smp[$];

  task automatic model_reset();
    m_pend = 0; m_inh = 0; m_take = 0; m_ret = 0; m_spur = 0; m_takes = 0;
    smp.delete();
    for (int unsigned i = 0; i < S + 1; i++) smp.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit ev, busy, nt, nr, ns;
    if (rst_i) begin
      model_reset();
      return;
    end
    // Request registers when INTR seen S edges ago was high and the edge before was low.
    ev   = smp[smp.size() - S] && !smp[smp.size() - S - 1];
    busy = m_take || m_ret;
    nt   = !busy && !m_inh && bnd_i && m_pend && mie_i;
    nr   = !busy && m_inh && bnd_i && mret_i;
    ns   = !busy && !m_inh && bnd_i && mret_i && !nt;
    if (m_take) m_takes++;
    m_pend = ev || (m_pend && !m_take);
    if (m_take) m_inh = 1;
    else if (m_ret) m_inh = 0;
    m_take = nt; m_ret = nr; m_spur = ns;
    smp.push_back(intr_i);
    if (smp.size() > S + 2) void'(smp.pop_front());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ea;
    ea = m_take ? mtvec_i : ((m_ret || m_spur) ? mepc_i : 32'h0);
    chk("int_taken", taken, m_take);
    chk("mie_clr", clr, m_take);
    chk("mie_set", set, m_ret);
    chk("redirect", redir, m_take || m_ret || m_spur);
    chk("redirect_addr", addr, ea);
    chk("pending", pend, m_pend);
    chk("in_isr", isr, m_inh);
    chk("int_count", cnt, (m_takes > 65535) ? 65535 : m_takes);
    chk("sat_int_count", s_cnt, (m_takes > 7) ? 7 : m_takes);
    chk("sat_redirect", s_redir, m_take || m_ret || m_spur);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit rst, intr, bnd, mret, mie;
    int ncyc;
    bit e_taken, e_clr, e_set, e_redir;
    bit [31:0] e_addr;
    bit e_pend, e_isr;
    bit [15:0] e_cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    model_reset();
    mtvec_i = 32'h100;
    mepc_i  = 32'h44;
    //          rst intr bnd mret mie  n  tk clr set rd addr     pd isr cnt
    tbl = '{
      '{1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 32'h0,   0, 0, 16'd0},
      '{0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0,   0, 0, 16'd0},
      '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 16'd0},
      '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 16'd0},
      '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   1, 0, 16'd0},
      '{0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 32'h100, 1, 0, 16'd0},
      '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 1, 16'd1},
      '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 32'h44,  0, 1, 16'd1},
      '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 16'd1},
      '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 32'h44,  0, 0, 16'd1},
      '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 16'd1},
      '{0, 1, 0, 0, 0, 4, 0, 0, 0, 0, 32'h0,   1, 0, 16'd1},
      '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0,   1, 0, 16'd1},
      '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   1, 0, 16'd1},
      '{0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 32'h100, 1, 0, 16'd1},
      '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 1, 16'd2},
      '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 16'd0},
      '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0,   0, 0, 16'd0}
    };

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      rst_i = tbl[i].rst; intr_i = tbl[i].intr; bnd_i = tbl[i].bnd;
      mret_i = tbl[i].mret; mie_i = tbl[i].mie;
      repeat (tbl[i].ncyc) tick();
      chk($sformatf("v%0d_taken", i), taken, tbl[i].e_taken);
      chk($sformatf("v%0d_clr", i), clr, tbl[i].e_clr);
      chk($sformatf("v%0d_set", i), set, tbl[i].e_set);
      chk($sformatf("v%0d_redir", i), redir, tbl[i].e_redir);
      chk($sformatf("v%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("v%0d_pend", i), pend, tbl[i].e_pend);
      chk($sformatf("v%0d_isr", i), isr, tbl[i].e_isr);
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].e_cnt);
    end
    bnd_i = 0;

    // Masked requests coalesce and wait; one take once MIE is set.
    mie_i = 0;
    for (int p = 0; p < 3; p++) begin
      intr_i = 1; tick(); tick();
      intr_i = 0; tick(); tick();
    end
    for (int b = 0; b < 5; b++) begin
      bnd_i = 1; tick();
      chk("masked_no_take", taken, 1'b0);
      bnd_i = 0; tick();
    end
    chk("masked_pending", pend, 1'b1);
    mie_i = 1; bnd_i = 1; tick();
    chk("unmasked_take", taken, 1'b1);
    bnd_i = 0; tick();
    chk("unmasked_count", cnt, 16'd1);
    bnd_i = 1; tick();
    chk("no_nesting", taken, 1'b0);
    bnd_i = 0; tick();

    // Edge during ISR stays pending and is taken after MRET once MIE returns.
    mie_i = 0;
    intr_i = 1; tick(); tick(); tick();
    intr_i = 0; tick();
    chk("isr_repending", pend, 1'b1);
    bnd_i = 1; mret_i = 1; tick();
    chk("ret_mie_set", set, 1'b1);
    chk("ret_addr", addr, 32'h44);
    bnd_i = 0; mret_i = 0; tick();
    chk("ret_idle_isr", isr, 1'b0);
    mie_i = 1; bnd_i = 1; tick();
    chk("second_take", taken, 1'b1);
    chk("second_take_addr", addr, 32'h100);
    bnd_i = 0; tick();
    chk("second_count", cnt, 16'd2);
    bnd_i = 1; mret_i = 1; tick();
    bnd_i = 0; mret_i = 0; tick();

    // Edge landing in the TAKE cycle survives the clear; then reset mid-ISR.
    intr_i = 1; tick(); tick(); tick();
    intr_i = 0; tick(); tick();
    intr_i = 1; tick();
    bnd_i = 1; tick();
    chk("setwins_take", taken, 1'b1);
    bnd_i = 0; tick();
    chk("setwins_pending", pend, 1'b1);
    chk("setwins_isr", isr, 1'b1);
    rst_i = 1; intr_i = 0; tick();
    chk("rst_isr", isr, 1'b0);
    chk("rst_pending", pend, 1'b0);
    chk("rst_count", cnt, 16'd0);
    chk("rst_redirect", redir, 1'b0);
    rst_i = 0; bnd_i = 1; mret_i = 0; tick();
    chk("post_rst_no_redirect", redir, 1'b0);
    bnd_i = 0; tick();

    // Nine takes: the 3-bit instance saturates, the 16-bit one keeps counting.
    for (int k = 0; k < 9; k++) begin
      intr_i = 1; tick(); tick(); tick();
      intr_i = 0; bnd_i = 1; tick();
      bnd_i = 0; tick();
      bnd_i = 1; mret_i = 1; tick();
      bnd_i = 0; mret_i = 0; tick();
    end
    chk("sat_hold", s_cnt, 3'd7);
    chk("nonsat_count", cnt, 16'd9);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_i = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) intr_i = ~intr_i;
      if ($urandom_range(0, 9) == 0) mie_i = ~mie_i;
      if ($urandom_range(0, 49) == 0) mtvec_i = $urandom;
      if ($urandom_range(0, 49) == 0) mepc_i = $urandom;
      bnd_i  = !(m_take || m_ret) && ($urandom_range(0, 2) == 0);
      mret_i = bnd_i && ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
